// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one byte with odd parity on device clock edges and checks the ack.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_ACK,
        WAIT_IDLE,
        FINISH
    } state_t;

    state_t            state_reg, state_next;
    logic              clk_meta_reg, clk_sync_reg, clk_prev_reg;
    logic              data_meta_reg, data_sync_reg;
    logic [7:0]        byte_reg, byte_next;
    logic              parity_reg, parity_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [INH_W-1:0]  inh_cnt_reg, inh_cnt_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              bit_oe_reg, bit_oe_next;
    logic              error_reg, error_next;

    logic              fall;
    logic [9:0]        frame;

    assign fall  = clk_prev_reg & ~clk_sync_reg;
    // Bits shifted after the start bit: data LSB first, parity, then stop.
    assign frame = {1'b1, parity_reg, byte_reg};

    // Synchronizers idle high so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            clk_prev_reg  <= 1'b1;
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
        end else begin
            clk_meta_reg  <= ps2_clk_in;
            clk_sync_reg  <= clk_meta_reg;
            clk_prev_reg  <= clk_sync_reg;
            data_meta_reg <= ps2_data_in;
            data_sync_reg <= data_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            byte_reg    <= '0;
            parity_reg  <= 1'b0;
            bit_cnt_reg <= '0;
            inh_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            bit_oe_reg  <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            byte_reg    <= byte_next;
            parity_reg  <= parity_next;
            bit_cnt_reg <= bit_cnt_next;
            inh_cnt_reg <= inh_cnt_next;
            to_cnt_reg  <= to_cnt_next;
            bit_oe_reg  <= bit_oe_next;
            error_reg   <= error_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        byte_next    = byte_reg;
        parity_next  = parity_reg;
        bit_cnt_next = bit_cnt_reg;
        inh_cnt_next = inh_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        bit_oe_next  = bit_oe_reg;
        error_next   = error_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    byte_next    = tx_byte;
                    parity_next  = ~^tx_byte;
                    bit_cnt_next = '0;
                    inh_cnt_next = '0;
                    to_cnt_next  = '0;
                    bit_oe_next  = 1'b0;
                    error_next   = 1'b0;
                    state_next   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_reg == INH_LAST) begin
                    to_cnt_next = '0;
                    state_next  = REQ;
                end else begin
                    inh_cnt_next = inh_cnt_reg + INH_W'(1);
                end
            end
            REQ, SEND, WAIT_ACK: begin
                if (fall) begin
                    to_cnt_next = '0;
                    if (state_reg == REQ) begin
                        bit_oe_next  = ~frame[0];
                        bit_cnt_next = 4'd1;
                        state_next   = SEND;
                    end else if (state_reg == SEND) begin
                        if (bit_cnt_reg == 4'd9) begin
                            bit_oe_next = 1'b0;
                            state_next  = WAIT_ACK;
                        end else begin
                            bit_oe_next  = ~frame[bit_cnt_reg];
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end else begin
                        // A released (high) data line at the ack edge is a missing ack.
                        error_next = data_sync_reg;
                        state_next = WAIT_IDLE;
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    error_next = 1'b1;
                    state_next = FINISH;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (clk_sync_reg && data_sync_reg) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line drivers are decoded from state so any exit (reset, timeout) releases them at once.
    assign ps2_clk_oe  = (state_reg == INHIBIT);
    assign ps2_data_oe = ((state_reg == INHIBIT) && (inh_cnt_reg == INH_LAST)) ||
                         (state_reg == REQ) ||
                         ((state_reg == SEND) && bit_oe_reg);
    assign busy        = (state_reg != IDLE) && (state_reg != FINISH);
    assign done        = (state_reg == FINISH);
    assign ack_err     = (state_reg == FINISH) && error_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-collector bus model with a behavioural PS/2 device,
// frame contents predicted from the byte's bits and its odd parity.
module tb_ps2_tx;

    localparam int INH  = 20;
    localparam int TO   = 300;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic done_ack_err = 1'b0;
    logic done_busy = 1'b0;
    logic done_oe = 1'b0;

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .tx_byte(tx_byte),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .ack_err(ack_err)
    );

    // Wired-AND bus: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_ack_err = ack_err;
            done_busy    = busy;
            done_oe      = ps2_clk_oe | ps2_data_oe;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line image: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit poke_start,
                             input int rst_edge);
        logic [10:0] got;
        logic [10:0] exp;
        int cnt, cnt_d, guard, done0;
        got   = '0;
        exp   = model_frame(b);
        done0 = done_cnt;
        @(negedge clk);
        tx_byte = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        tx_byte = 8'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        cnt   = 0;
        cnt_d = 0;
        while (ps2_clk_oe && cnt < INH + 50) begin
            if (ps2_data_oe) cnt_d++;
            cnt++;
            if (poke_start && cnt == 3) begin
                start   = 1'b1;
                tx_byte = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("inhibit_len", cnt, INH);
        check("inhibit_data_last", cnt_d, 1);
        check("req_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
        repeat (HALF) @(negedge clk);
        got[0] = ps2_data_in;
        for (int e = 1; e <= 10; e++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            got[e] = ps2_data_in;
            if (e == rst_edge) begin
                check("bits_before_rst", 32'(got[5:0]), 32'(exp[5:0]));
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                rst_n = 1'b1;
                repeat (100) @(negedge clk);
                check("no_done_after_rst", done_cnt - done0, 0);
                $display("frame byte=%02h reset after edge %0d", b, e);
                return;
            end
        end
        if (ack) dev_data = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
        check("frame", 32'(got), 32'(exp));
        check("parity_bit", 32'(got[9]), 32'(exp[9]));
        guard = 0;
        while (done_cnt == done0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", done_cnt - done0, 1);
        check("ack_err", 32'(done_ack_err), 32'(!ack));
        check("busy_at_done", 32'(done_busy), 32'd0);
        check("oe_at_done", 32'(done_oe), 32'd0);
        repeat (50) @(negedge clk);
        check("single_done", done_cnt - done0, 1);
        check("lines_idle", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        $display("frame byte=%02h ack=%0d line=%03h expected=%03h", b, ack, got, exp);
    endtask

    task automatic run_timeout(input logic [7:0] b);
        int guard, el;
        @(negedge clk);
        tx_byte = b;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (ps2_clk_oe && guard < INH + 50) begin
            @(negedge clk);
            guard++;
        end
        el = 0;
        while (!done && el < TO + 50) begin
            @(negedge clk);
            el++;
        end
        check("timeout_latency", el, TO);
        check("timeout_ack_err", 32'(ack_err), 32'd1);
        check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("timeout_idle_busy", 32'(busy), 32'd0);
        $display("timeout byte=%02h latency=%0d", b, el);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(8'hED, 1'b1, 1'b0, 0);
        run_frame(8'h02, 1'b1, 1'b0, 0);
        run_frame(8'hFF, 1'b1, 1'b0, 0);
        run_frame(8'hED, 1'b0, 1'b0, 0);
        run_frame(8'hED, 1'b1, 1'b1, 0);
        run_timeout(8'h5A);
        run_frame(8'hED, 1'b1, 1'b0, 5);
        for (int i = 0; i < 8; i++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
